// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
package keypad_pkg;

  // Key code for each switch, indexed {row, col}
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Scan result / candidate: bit4 set means "no single key"
  localparam logic [4:0] KEY_NONE = 5'b1_0000;

  // Column drive while in reset (column 0 selected)
  localparam logic [3:0] COL_IDLE = 4'b0111;

  // Column currently driven low
  typedef enum logic [1:0] {
    COL_0 = 2'd0,
    COL_1 = 2'd1,
    COL_2 = 2'd2,
    COL_3 = 2'd3
  } col_state_t;

  // Active-low one-hot column drive for column index c
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b1000 >> c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row lines; resets to all ones (no key).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values: shift the input through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column sequencing, per-scan hit collection with ghost
// rejection, scan-level debounce and single-pulse key acceptance.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_CYCLES     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid,
  output logic       key_pulse,
  output logic       scan_done
);

  localparam int CNT_W = $clog2(COL_CYCLES);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  logic [3:0] row_sync;

  col_state_t       col_state_q, col_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;   // hits so far this scan, saturates at 2
  logic [3:0]       hit_idx_q, hit_idx_d;   // {row, col} of the last hit this scan
  logic [4:0]       cand_q, cand_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [3:0]       decode_q, decode_d;
  logic             key_valid_q, key_valid_d;
  logic             key_pulse_q, key_pulse_d;
  logic             scan_done_q, scan_done_d;

  logic       sample;
  logic [1:0] n_hits;
  logic [3:0] n_idx;
  logic [4:0] scan_res;

  sync_2ff #(.W(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  // Column sequencing, hit accumulation, debounce and acceptance
  always_comb begin
    col_state_d = col_state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    hit_cnt_d   = hit_cnt_q;
    hit_idx_d   = hit_idx_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    decode_d    = decode_q;
    key_valid_d = key_valid_q;
    key_pulse_d = 1'b0;
    scan_done_d = 1'b0;
    n_hits      = hit_cnt_q;
    n_idx       = hit_idx_q;
    scan_res    = KEY_NONE;
    sample      = (cnt_q == CNT_LAST);

    if (!sample) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d       = '0;
      col_state_d = col_state_t'(col_state_q + 2'd1);
      col_d       = col_drive(col_state_d);

      // Fold this column's pressed rows into the scan's running tally
      for (int r = 0; r < 4; r++) begin
        if (!row_sync[3-r]) begin
          if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
          n_idx = {2'(r), col_state_q};
        end
      end
      hit_cnt_d = n_hits;
      hit_idx_d = n_idx;

      if (col_state_q == COL_3) begin
        scan_done_d = 1'b1;
        hit_cnt_d   = '0;
        hit_idx_d   = '0;
        // Exactly one closed switch gives a key; none or several give NONE
        scan_res    = (n_hits == 2'd1) ? {1'b0, KEY_MAP[n_idx]} : KEY_NONE;

        if (scan_res == cand_q) begin
          if (stable_q != STB_MAX) stable_d = stable_q + STB_W'(1);
        end else begin
          cand_d   = scan_res;
          stable_d = STB_W'(1);
        end

        if (stable_d == STB_MAX) begin
          if (!cand_d[4] && (!key_valid_q || cand_d[3:0] != decode_q)) begin
            decode_d    = cand_d[3:0];
            key_valid_d = 1'b1;
            key_pulse_d = 1'b1;
          end else if (cand_d[4] && key_valid_q) begin
            key_valid_d = 1'b0;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_state_q <= COL_0;
      cnt_q       <= '0;
      col_q       <= COL_IDLE;
      hit_cnt_q   <= '0;
      hit_idx_q   <= '0;
      cand_q      <= KEY_NONE;
      stable_q    <= '0;
      decode_q    <= 4'h0;
      key_valid_q <= 1'b0;
      key_pulse_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      col_state_q <= col_state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_idx_q   <= hit_idx_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      decode_q    <= decode_d;
      key_valid_q <= key_valid_d;
      key_pulse_q <= key_pulse_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign col       = col_q;
  assign decode    = decode_q;
  assign key_valid = key_valid_q;
  assign key_pulse = key_pulse_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: physical keypad model, scan-level reference
// model, table of hand-derived vectors and randomized scans.
module tb_keypad_scanner;

  localparam int CC   = 4;
  localparam int DS   = 2;
  localparam int SCAN = 4 * CC;

  localparam logic [15:0] K1 = 16'h0001;  // r0 c0
  localparam logic [15:0] K5 = 16'h0020;  // r1 c1
  localparam logic [15:0] K6 = 16'h0040;  // r1 c2
  localparam logic [15:0] K9 = 16'h0400;  // r2 c2
  localparam logic [15:0] KD = 16'h8000;  // r3 c3

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row, col, decode;
  logic        key_valid, key_pulse, scan_done;
  logic [15:0] pressed = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.COL_CYCLES(CC), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .decode    (decode),
    .key_valid (key_valid),
    .key_pulse (key_pulse),
    .scan_done (scan_done)
  );

  // Keypad: a closed switch pulls its row low while its column is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[3-c]) row[3-r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Reference model: works on whole-scan key sets
  int         codes [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int         m_cand, m_stable;
  bit         m_valid, m_pulse;
  logic [3:0] m_dec;

  task automatic model_reset();
    m_cand = -1; m_stable = 0; m_valid = 0; m_pulse = 0; m_dec = 4'h0;
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int res;
    res = -1;
    if ($countones(mask) == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) res = codes[i];
    if (res == m_cand) m_stable = (m_stable < DS) ? m_stable + 1 : DS;
    else begin m_cand = res; m_stable = 1; end
    m_pulse = 0;
    if (m_stable == DS) begin
      if (m_cand >= 0 && (!m_valid || m_cand != int'(m_dec))) begin
        m_dec = 4'(m_cand); m_valid = 1; m_pulse = 1;
      end else if (m_cand < 0) begin
        m_valid = 0;
      end
    end
  endtask

  // Wait (bounded) for the next scan_done; key_pulse must stay low meanwhile
  task automatic wait_scan(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * SCAN; i++) begin
      @(negedge clk);
      if (scan_done) begin ok = 1; break; end
      check("pulse_between_scans", key_pulse, 0);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL scan_done_timeout: got no strobe expected strobe within %0d cycles", 3 * SCAN);
    end
  endtask

  task automatic scan_step(input logic [15:0] mask, input bit ep, input bit ev,
                           input logic [3:0] ed, input string tag);
    bit ok;
    pressed = mask;
    wait_scan(ok);
    if (ok) begin
      check({tag, ".pulse"}, key_pulse, ep);
      check({tag, ".valid"}, key_valid, ev);
      check({tag, ".decode"}, decode, ed);
    end
  endtask

  task automatic model_step(input logic [15:0] mask, input string tag);
    bit ok;
    pressed = mask;
    wait_scan(ok);
    model_scan(mask);
    if (ok) begin
      check({tag, ".pulse"}, key_pulse, m_pulse);
      check({tag, ".valid"}, key_valid, m_valid);
      check({tag, ".decode"}, decode, m_dec);
    end
  endtask

  task automatic do_reset(input logic [15:0] mask);
    rst = 1'b0;
    pressed = mask;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".col"}, col, 4'b0111);
    check({tag, ".decode"}, decode, 4'h0);
    check({tag, ".valid"}, key_valid, 0);
    check({tag, ".pulse"}, key_pulse, 0);
    check({tag, ".scan_done"}, scan_done, 0);
  endtask

  typedef struct {
    logic [15:0] mask;
    bit          pulse;
    bit          valid;
    logic [3:0]  dec;
  } vec_t;

  vec_t vecs [21];

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  one_hot;
    logic [3:0]  exp_col;
    logic [15:0] one16;
    logic [15:0] m, prev;
    int          n;
    bit          got;

    one_hot = 4'b1000;
    one16   = 16'h0001;

    // Scan-by-scan expectations after reset, one key set per scan
    vecs[0]  = '{K5,      0, 0, 4'h0};
    vecs[1]  = '{K5,      1, 1, 4'h5};
    vecs[2]  = '{K5,      0, 1, 4'h5};
    vecs[3]  = '{K5,      0, 1, 4'h5};
    vecs[4]  = '{16'h0,   0, 1, 4'h5};
    vecs[5]  = '{16'h0,   0, 0, 4'h5};
    vecs[6]  = '{K9,      0, 0, 4'h5};
    vecs[7]  = '{16'h0,   0, 0, 4'h5};
    vecs[8]  = '{K9,      0, 0, 4'h5};
    vecs[9]  = '{16'h0,   0, 0, 4'h5};
    vecs[10] = '{K1 | K6, 0, 0, 4'h5};
    vecs[11] = '{K1 | K6, 0, 0, 4'h5};
    vecs[12] = '{K1,      0, 0, 4'h5};
    vecs[13] = '{K1,      1, 1, 4'h1};
    vecs[14] = '{KD,      0, 1, 4'h1};
    vecs[15] = '{KD,      1, 1, 4'hD};
    vecs[16] = '{16'h0,   0, 1, 4'hD};
    vecs[17] = '{16'h0,   0, 0, 4'hD};
    vecs[18] = '{16'h0,   0, 0, 4'hD};
    vecs[19] = '{KD,      0, 0, 4'hD};
    vecs[20] = '{KD,      1, 1, 4'hD};

    // Reset state
    rst = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Column stepping and scan_done period after release
    rst = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      exp_col = ~(one_hot >> ((k / 4) % 4));
      check($sformatf("colseq[%0d].col", k), col, exp_col);
      check($sformatf("colseq[%0d].scan_done", k), scan_done, (k % 16) == 0);
    end

    // Vector table
    do_reset('0);
    for (int i = 0; i < 21; i++)
      scan_step(vecs[i].mask, vecs[i].pulse, vecs[i].valid, vecs[i].dec, $sformatf("vec[%0d]", i));

    // Press mid-scan: pulse within (DS+1) scans + 1 cycle
    do_reset('0);
    repeat (7) @(negedge clk);
    pressed = K5;
    n = 0;
    got = 0;
    for (int i = 1; i <= 4 * SCAN; i++) begin
      @(negedge clk);
      if (key_pulse) begin n = i; got = 1; break; end
    end
    check("latency.seen", got, 1);
    check("latency.bound", (n <= (DS + 1) * SCAN + 1), 1);
    check("latency.decode", decode, 4'h5);
    check("latency.valid", key_valid, 1);

    // Reset asserted mid-column while '5' is accepted and held
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) model_step(K5, $sformatf("after_reset[%0d]", i));

    // Randomized scans against the reference model
    do_reset('0);
    model_reset();
    prev = '0;
    for (int i = 0; i < 80; i++) begin
      m = prev;
      if ($urandom_range(0, 1) == 1) begin
        int sel, a, b;
        sel = $urandom_range(0, 9);
        a   = $urandom_range(0, 15);
        b   = (a + 1 + $urandom_range(0, 14)) % 16;
        if (sel < 4)      m = '0;
        else if (sel < 8) m = one16 << a;
        else              m = (one16 << a) | (one16 << b);
      end
      prev = m;
      model_step(m, $sformatf("rand[%0d]", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
